// File: rtl/array_sort_control_if.sv
// array_sort_control_if
//   Bundles the control handshake, the register-file read/write bus and the
//   status outputs of the array sort sequencer.
//
//   Signals:
//     go, array, length        start request, base index, element count
//     rd_addr_a/b, rd_data_a/b two asynchronous register-file read ports
//     wr_enable/addr/data      single register-file write port
//     busy, done, was_sorted,  run status
//     swap_count
//
//   Modports:
//     slave  - the sequencer itself
//     master - the host side (start control plus the register file)
interface array_sort_control_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 9
);
  logic              go;
  logic [ADDR_W-1:0] array;
  logic [ADDR_W-1:0] length;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              was_sorted;
  logic [CNT_W-1:0]  swap_count;

  modport slave (
    input  go, array, length, rd_data_a, rd_data_b,
    output rd_addr_a, rd_addr_b, wr_enable, wr_addr, wr_data,
    output busy, done, was_sorted, swap_count
  );

  modport master (
    output go, array, length, rd_data_a, rd_data_b,
    input  rd_addr_a, rd_addr_b, wr_enable, wr_addr, wr_data,
    input  busy, done, was_sorted, swap_count
  );
endinterface

// File: rtl/array_sort_control.sv
// array_sort_control
//   Bubble-sorts, in place and in ascending signed order, a contiguous window
//   of a 32-entry register file. One compare per cycle; a swap costs two write
//   cycles. Stops early after a pass with no swap.
//
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high reset
//     sif    array_sort_control_if.slave: go/array/length in, register-file
//            read/write bus, busy/done/was_sorted/swap_count status out
module array_sort_control #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  array_sort_control_if.slave  sif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COMPARE  = 3'd1;
  localparam logic [2:0] S_SWAP1    = 3'd2;
  localparam logic [2:0] S_SWAP2    = 3'd3;
  localparam logic [2:0] S_PASS_END = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] limit;
  logic              pass_swapped;
  logic              first_pass;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic [CNT_W-1:0]  swap_count;
  logic              done;
  logic              was_sorted;

  logic [ADDR_W-1:0] j_next;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;

  // Index arithmetic wraps naturally at ADDR_W bits, so a window starting
  // near the top of the register file continues at r0.
  assign j_next  = j + ADDR_W'(1);
  assign addr_lo = base + j;
  assign addr_hi = base + j_next;

  // Sequencer. limit is the number of compares in the current pass; it
  // shrinks by one after each pass because the largest element has bubbled
  // to the end of the window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      base         <= '0;
      j            <= '0;
      limit        <= '0;
      pass_swapped <= 1'b0;
      first_pass   <= 1'b0;
      lat_a        <= '0;
      lat_b        <= '0;
      swap_count   <= '0;
      done         <= 1'b0;
      was_sorted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sif.go) begin
            base         <= sif.array;
            limit        <= sif.length - ADDR_W'(1);
            j            <= '0;
            done         <= 1'b0;
            swap_count   <= '0;
            pass_swapped <= 1'b0;
            first_pass   <= 1'b1;
            // Zero or one element is trivially sorted.
            if (sif.length < ADDR_W'(2)) begin
              was_sorted <= 1'b1;
              state      <= S_DONE;
            end else begin
              was_sorted <= 1'b0;
              state      <= S_COMPARE;
            end
          end
        end

        S_COMPARE: begin
          // Strict greater-than keeps equal elements in order.
          if ($signed(sif.rd_data_a) > $signed(sif.rd_data_b)) begin
            lat_a <= sif.rd_data_a;
            lat_b <= sif.rd_data_b;
            state <= S_SWAP1;
          end else begin
            j     <= j_next;
            state <= (j_next == limit) ? S_PASS_END : S_COMPARE;
          end
        end

        S_SWAP1: begin
          state <= S_SWAP2;
        end

        S_SWAP2: begin
          swap_count   <= swap_count + CNT_W'(1);
          pass_swapped <= 1'b1;
          j            <= j_next;
          state        <= (j_next == limit) ? S_PASS_END : S_COMPARE;
        end

        S_PASS_END: begin
          if (first_pass) begin
            was_sorted <= !pass_swapped;
            first_pass <= 1'b0;
          end
          if (!pass_swapped || limit == ADDR_W'(1)) begin
            state <= S_DONE;
          end else begin
            limit        <= limit - ADDR_W'(1);
            j            <= '0;
            pass_swapped <= 1'b0;
            state        <= S_COMPARE;
          end
        end

        S_DONE: begin
          done <= 1'b1;
          if (!sif.go) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from the state so that a reset removes the
  // write strobe immediately rather than one edge later.
  always_comb begin
    sif.busy      = (state != S_IDLE) && (state != S_DONE);
    sif.rd_addr_a = '0;
    sif.rd_addr_b = '0;
    sif.wr_enable = 1'b0;
    sif.wr_addr   = '0;
    sif.wr_data   = '0;
    case (state)
      S_COMPARE: begin
        sif.rd_addr_a = addr_lo;
        sif.rd_addr_b = addr_hi;
      end
      S_SWAP1: begin
        sif.wr_enable = 1'b1;
        sif.wr_addr   = addr_lo;
        sif.wr_data   = lat_b;
      end
      S_SWAP2: begin
        sif.wr_enable = 1'b1;
        sif.wr_addr   = addr_hi;
        sif.wr_data   = lat_a;
      end
      default: begin
      end
    endcase
  end

  assign sif.done       = done;
  assign sif.was_sorted = was_sorted;
  assign sif.swap_count = swap_count;

endmodule

// File: tb/tb_array_sort_control.sv
// tb_array_sort_control
//   Bench for array_sort_control. Provides a 32x32 register file with
//   asynchronous reads and edge-triggered writes, drives directed and random
//   sort requests, and checks results from a scoreboard of expectations
//   computed when each request is issued.
module tb_array_sort_control;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  array_sort_control_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(9)) sif ();

  array_sort_control #(.ADDR_W(5), .DATA_W(32), .CNT_W(9)) dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif)
  );

  // Register file model.
  logic [31:0] rf      [32];
  logic [31:0] exp_mem [32];

  assign sif.rd_data_a = rf[sif.rd_addr_a];
  assign sif.rd_data_b = rf[sif.rd_addr_b];

  int         write_count;
  int         bad_writes;
  logic [4:0] mon_base;
  logic [4:0] mon_len;
  bit         busy_seen;

  // Write port plus a monitor that flags writes outside the active window.
  always @(posedge clock) begin
    if (sif.wr_enable === 1'b1) begin
      rf[sif.wr_addr] <= sif.wr_data;
      write_count++;
      if (5'(sif.wr_addr - mon_base) >= mon_len) bad_writes++;
    end
  end

  always @(negedge clock) begin
    if (sif.busy === 1'b1) busy_seen = 1'b1;
  end

  typedef struct packed {
    logic [8:0]  swaps;
    logic        sorted;
    logic [15:0] writes;
    logic [15:0] latency;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Expected result: ascending signed order, swap count equal to the number
  // of inversions in the window, and a latency that is only fixed when the
  // window starts out sorted.
  task automatic push_expect(input logic [4:0] b, input logic [4:0] n);
    logic signed [31:0] v [32];
    logic signed [31:0] key;
    int   inv;
    int   k;
    exp_t e;
    inv = 0;
    for (int i = 0; i < int'(n); i++) v[i] = rf[(int'(b) + i) % 32];
    for (int i = 0; i < int'(n); i++)
      for (int m = i + 1; m < int'(n); m++)
        if (v[i] > v[m]) inv++;
    for (int i = 1; i < int'(n); i++) begin
      key = v[i];
      k = i - 1;
      while (k >= 0 && v[k] > key) begin
        v[k+1] = v[k];
        k--;
      end
      v[k+1] = key;
    end
    for (int i = 0; i < 32; i++) exp_mem[i] = rf[i];
    for (int i = 0; i < int'(n); i++) exp_mem[(int'(b) + i) % 32] = v[i];
    e.swaps   = 9'(inv);
    e.sorted  = (inv == 0);
    e.writes  = 16'(2 * inv);
    e.latency = (inv != 0) ? 16'hFFFF : ((n < 5'd2) ? 16'd1 : 16'(int'(n) + 1));
    e.busy    = (n >= 5'd2);
    sb.push_back(e);
  endtask

  task automatic check_output(input string tag, input int lat);
    exp_t e;
    int   nbad;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard entry"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " done"},        64'(sif.done),       64'd1);
    chk({tag, " swap_count"},  64'(sif.swap_count), 64'(e.swaps));
    chk({tag, " was_sorted"},  64'(sif.was_sorted), 64'(e.sorted));
    chk({tag, " write cycles"}, 64'(write_count),   64'(e.writes));
    chk({tag, " stray writes"}, 64'(bad_writes),    64'd0);
    chk({tag, " busy seen"},   64'(busy_seen),      64'(e.busy));
    if (e.latency != 16'hFFFF)
      chk({tag, " latency"}, 64'(lat), 64'(e.latency));
    nbad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_mem[i]) nbad++;
    chk({tag, " memory mismatches"}, 64'(nbad), 64'd0);
  endtask

  // Issue one sort request with go high for go_cycles edges (including the
  // accepting edge), then wait a bounded time for done.
  task automatic apply_stimulus(input string tag, input logic [4:0] b,
                                input logic [4:0] n, input int go_cycles);
    int k;
    push_expect(b, n);
    write_count = 0;
    bad_writes  = 0;
    busy_seen   = 1'b0;
    mon_base    = b;
    mon_len     = n;
    @(negedge clock);
    sif.array  = b;
    sif.length = n;
    sif.go     = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, " done cleared on accept"}, 64'(sif.done), 64'd0);
    k = 0;
    while (sif.done !== 1'b1 && k < 3000) begin
      @(negedge clock);
      sif.go = (k + 1 < go_cycles);
      @(posedge clock);
      k++;
      #1;
    end
    sif.go = 1'b0;
    check_output(tag, k);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int idx;
    logic [4:0] rb;
    logic [4:0] rn;

    reset      = 1'b1;
    sif.go     = 1'b0;
    sif.array  = '0;
    sif.length = '0;
    mon_base   = '0;
    mon_len    = '0;
    write_count = 0;
    bad_writes  = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);

    @(negedge clock);
    chk("reset busy",       64'(sif.busy),       64'd0);
    chk("reset done",       64'(sif.done),       64'd0);
    chk("reset was_sorted", 64'(sif.was_sorted), 64'd0);
    chk("reset wr_enable",  64'(sif.wr_enable),  64'd0);
    chk("reset swap_count", 64'(sif.swap_count), 64'd0);
    chk("reset rd_addr_a",  64'(sif.rd_addr_a),  64'd0);
    chk("reset rd_addr_b",  64'(sif.rd_addr_b),  64'd0);
    chk("reset wr_addr",    64'(sif.wr_addr),    64'd0);
    chk("reset wr_data",    64'(sif.wr_data),    64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] already sorted r11..r15");
    apply_stimulus("sorted", 5'd11, 5'd5, 5);

    $display("[TB] one swap r2..r6");
    rf[2] = 1; rf[3] = 2; rf[4] = 3; rf[5] = 2; rf[6] = 5;
    apply_stimulus("oneswap", 5'd2, 5'd5, 1);

    $display("[TB] wrap-around window");
    rf[30] = 9; rf[31] = 8; rf[0] = 7; rf[1] = 6;
    apply_stimulus("wrap", 5'd30, 5'd4, 1);

    $display("[TB] signed and equal values");
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd0;
    apply_stimulus("neg_first", 5'd1, 5'd2, 1);
    rf[1] = 32'd1; rf[2] = 32'hFFFF_FFFF;
    apply_stimulus("neg_second", 5'd1, 5'd2, 1);
    for (int i = 1; i <= 6; i++) rf[i] = 32'd3;
    apply_stimulus("equal", 5'd1, 5'd6, 1);

    $display("[TB] short lengths");
    apply_stimulus("len0", 5'd5, 5'd0, 1);
    apply_stimulus("len1", 5'd5, 5'd1, 1);

    $display("[TB] reset during first swap");
    rf[2] = 1; rf[3] = 2; rf[4] = 3; rf[5] = 2; rf[6] = 5;
    mon_base    = 5'd2;
    mon_len     = 5'd5;
    write_count = 0;
    @(negedge clock);
    sif.array  = 5'd2;
    sif.length = 5'd5;
    sif.go     = 1'b1;
    @(negedge clock);
    sif.go = 1'b0;
    k = 0;
    while (sif.wr_enable !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("abort reached swap", 64'(sif.wr_enable), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort wr_enable", 64'(sif.wr_enable), 64'd0);
    chk("abort busy",      64'(sif.busy),      64'd0);
    chk("abort done",      64'(sif.done),      64'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("abort no write",  64'(write_count),   64'd0);
    chk("abort r4 intact", 64'(rf[4]),         64'd3);
    apply_stimulus("rerun", 5'd2, 5'd5, 1);

    $display("[TB] random windows");
    for (int r = 0; r < 3; r++) begin
      rb = 5'($urandom_range(0, 31));
      rn = 5'($urandom_range(2, 10));
      for (int i = 0; i < int'(rn); i++) begin
        idx = (int'(rb) + i) % 32;
        rf[idx] = 32'(int'($urandom_range(0, 15)) - 8);
      end
      apply_stimulus("random", rb, rn, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
